mem_arbiter: RTL

Sequential byte-bus arbiter sitting directly between the pipeline's fetch and memory-access stages and the external 8-bit RAM/IO bus of the CPU top.
- Serialises 32-bit instruction fetches and 1/2/4-byte data loads/stores into byte transfers.
- Assembles read words little-endian and returns them with a one-cycle done pulse.
- Gives the data side priority over fetch, and freezes cleanly while rdy_in is low.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM/IO bus arbiter for fetch and data accesses
// Optional: MEM_ARBITER_IF_ABORT_EN adds if_abort, which drops an in-flight fetch.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
`ifdef MEM_ARBITER_IF_ABORT_EN
  input  logic              if_abort,
`endif
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_inst_d, mem_rdata_d;
  logic [2:0]        ip_q, ip_d;
  logic [2:0]        cp_q, cp_d;
  logic              is_mem_q, is_mem_d;
  logic [2:0]        n_bytes;
  logic              io_addr;
  logic              abort;

  assign n_bytes = {1'b0, last_q} + 3'd1;
  assign io_addr = (addr_q[17:16] == IO_HI);

`ifdef MEM_ARBITER_IF_ABORT_EN
  assign abort = if_abort && (state_q == IF_RD);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      last_q    <= 2'd0;
      wdata_q   <= 32'd0;
      buf_q     <= 32'd0;
      ip_q      <= 3'd0;
      cp_q      <= 3'd0;
      is_mem_q  <= 1'b0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      ip_q      <= ip_d;
      cp_q      <= cp_d;
      is_mem_q  <= is_mem_d;
      if_inst   <= if_inst_d;
      mem_rdata <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ip_d        = ip_q;
    cp_d        = cp_q;
    is_mem_d    = is_mem_q;
    if_inst_d   = if_inst;
    mem_rdata_d = mem_rdata;
    ram_a       = '0;
    ram_wr      = 1'b0;
    ram_dout    = 8'd0;
    if_done     = 1'b0;
    mem_done    = 1'b0;

    if (abort) begin
      state_d = IDLE;
      ip_d    = 3'd0;
      cp_d    = 3'd0;
    end else if (!rdy_in) begin
      // Anything issued but not captured is lost; re-issue it on resume.
      if (state_q == IF_RD || state_q == MEM_RD)
        ip_d = cp_q;
    end else begin
      case (state_q)
        IDLE: begin
          ip_d  = 3'd0;
          cp_d  = 3'd0;
          buf_d = 32'd0;
          if (mem_req) begin
            state_d  = mem_rw ? MEM_WR : MEM_RD;
            addr_d   = mem_addr;
            last_d   = (mem_len == 2'd0) ? 2'd0 : (mem_len == 2'd1) ? 2'd1 : 2'd3;
            wdata_d  = mem_wdata;
            is_mem_d = 1'b1;
          end else if (if_req) begin
            state_d  = IF_RD;
            addr_d   = if_addr;
            last_d   = 2'd3;
            is_mem_d = 1'b0;
          end
        end
        IF_RD, MEM_RD: begin
          // I/O space never has more than one byte in flight.
          if (ip_q < n_bytes && (!io_addr || ip_q == cp_q)) begin
            ram_a = addr_q + ADDR_W'(ip_q);
            ip_d  = ip_q + 3'd1;
          end
          if (cp_q < ip_q) begin
            buf_d[{cp_q[1:0], 3'b000} +: 8] = ram_din;
            cp_d = cp_q + 3'd1;
            if (cp_d == n_bytes) begin
              state_d = DONE;
              if (is_mem_q) mem_rdata_d = buf_d;
              else          if_inst_d   = buf_d;
            end
          end
        end
        MEM_WR: begin
          ram_a    = addr_q + ADDR_W'(ip_q);
          ram_wr   = 1'b1;
          ram_dout = wdata_q[{ip_q[1:0], 3'b000} +: 8];
          ip_d     = ip_q + 3'd1;
          if (ip_q == {1'b0, last_q})
            state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          if (is_mem_q) mem_done = 1'b1;
          else          if_done  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
